// File: rtl/proc_pkg.sv
// ============================================================
// proc_pkg : shared types and instruction-field constants
// Rev 1.0
// ============================================================
`default_nettype none

package proc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Bit 0 selects IR, bit 1 selects MDR
  typedef enum logic [1:0] {
    DST_NONE = 2'b00,
    DST_IR   = 2'b01,
    DST_MDR  = 2'b10,
    DST_BOTH = 2'b11
  } mem_dst_t;

  localparam int OPC_LSB   = 0;
  localparam int OPC_W     = 3;
  localparam int FUNCT_LSB = 3;
  localparam int FUNCT_W   = 4;

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================
// mem_wait_timer : clear/enable counter saturating at LIMIT
// Rev 1.0
// ============================================================
`default_nettype none

module mem_wait_timer #(
  parameter int LIMIT = 15,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  assign expired = (count == CNT_W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================
// mem_access_unit : req/ack memory stage owning IR and MDR
// Rev 1.0
// ============================================================
`default_nettype none

module mem_access_unit
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IoD,
  input  logic              IRWrite,
  input  logic              MemR,
  input  logic              MemW,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [6:0]        input_control,
  output logic              stall,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t       state;
  mem_dst_t         dst;
  mem_dst_t         new_dst;
  logic             any_strobe;
  logic             busy;
  logic             expired;
  logic [CNT_W-1:0] wait_count;

  assign any_strobe    = IRWrite | MemR | MemW;
  assign busy          = (state == BUSY);
  assign input_control = ir[FUNCT_LSB+FUNCT_W-1:OPC_LSB];

  // The processor may advance in the cycle a transaction completes or aborts
  assign stall = busy ? !(mem_ack || expired) : any_strobe;

  always_comb begin
    new_dst = DST_NONE;
    if (!MemW) begin
      if (IRWrite && MemR) new_dst = DST_BOTH;
      else if (IRWrite)    new_dst = DST_IR;
      else if (MemR)       new_dst = DST_MDR;
    end
  end

  mem_wait_timer #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk     (CLK),
    .rst     (Reset),
    .clear   (!busy || mem_ack || expired),
    .enable  (busy),
    .count   (wait_count),
    .expired (expired)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      dst       <= DST_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
      bus_err   <= 1'b0;
    end else if (!busy) begin
      if (any_strobe) begin
        state     <= BUSY;
        dst       <= new_dst;
        mem_req   <= 1'b1;
        mem_we    <= MemW;
        mem_addr  <= IoD ? alu_out : pc;
        mem_wdata <= wdata;
        // A write colliding with a read strobe wins, but is flagged
        if (MemW && (IRWrite || MemR)) bus_err <= 1'b1;
      end
    end else if (mem_ack) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      if (dst == DST_IR  || dst == DST_BOTH) ir  <= mem_rdata;
      if (dst == DST_MDR || dst == DST_BOTH) mdr <= mem_rdata;
    end else if (expired) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      bus_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================
// tb_mem_access_unit : table, directed and random checks
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        CLK, Reset, IoD, IRWrite, MemR, MemW, mem_ack;
  logic [15:0] pc, alu_out, wdata, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, ir, mdr;
  logic        mem_req, mem_we, stall, bus_err;
  logic [6:0]  input_control;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iod, irw, mr, mw;
    logic [15:0] pc, alu, wd, rd;
    int          delay;
    logic [15:0] e_addr;
    logic        e_we;
    int          e_stall;
    logic [15:0] e_ir, e_mdr;
    logic        e_berr;
  } vec_t;

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .IoD(IoD), .IRWrite(IRWrite), .MemR(MemR), .MemW(MemW),
    .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ir(ir), .mdr(mdr), .input_control(input_control), .stall(stall), .bus_err(bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one access with ack after v.delay BUSY cycles (or never) and checks it
  task automatic run_access(input vec_t v);
    int stalls = 0;
    @(negedge CLK);
    IoD = v.iod; IRWrite = v.irw; MemR = v.mr; MemW = v.mw;
    pc = v.pc; alu_out = v.alu; wdata = v.wd; mem_ack = 1'b0; mem_rdata = ~v.rd;
    #1;
    check("strobe_stall", 32'(stall), 1);
    if (stall) stalls++;
    @(negedge CLK);
    IRWrite = 1'b0; MemR = 1'b0; MemW = 1'b0;
    check("req_rise", 32'(mem_req), 1);
    check("mem_addr", 32'(mem_addr), 32'(v.e_addr));
    check("mem_we", 32'(mem_we), 32'(v.e_we));
    if (v.e_we) check("mem_wdata", 32'(mem_wdata), 32'(v.wd));
    for (int c = 0; c <= TIMEOUT; c++) begin
      mem_ack   = (c == v.delay);
      mem_rdata = (c == v.delay) ? v.rd : ~v.rd;
      #1;
      if (stall) stalls++;
      if (c == v.delay || c == TIMEOUT) check("final_stall", 32'(stall), 0);
      @(negedge CLK);
      mem_ack = 1'b0;
      if (c == v.delay || c == TIMEOUT) break;
      check("req_hold", 32'({mem_req, mem_addr}), 32'({1'b1, v.e_addr}));
    end
    check("req_fall", 32'(mem_req), 0);
    check("stall_cycles", 32'(stalls), 32'(v.e_stall));
    check("ir", 32'(ir), 32'(v.e_ir));
    check("mdr", 32'(mdr), 32'(v.e_mdr));
    check("input_control", 32'(input_control), 32'(v.e_ir[6:0]));
    check("bus_err", 32'(bus_err), 32'(v.e_berr));
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  vec_t table_v[5];
  vec_t v;
  logic [15:0] m_ir, m_mdr;
  logic        m_berr;
  logic        acked;

  initial begin
    Reset = 1'b1; IoD = 0; IRWrite = 0; MemR = 0; MemW = 0; mem_ack = 0;
    pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0;

    //            iod irw mr mw  pc        alu       wd        rd        dly addr      we stall ir        mdr       berr
    table_v[0] = '{0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h1234,  2, 16'h0010, 0,  3, 16'h1234, 16'h0000, 0};
    table_v[1] = '{1, 0, 1, 0, 16'h0000, 16'h0200, 16'h0000, 16'hBEEF,  0, 16'h0200, 0,  1, 16'h1234, 16'hBEEF, 0};
    table_v[2] = '{1, 0, 0, 1, 16'h0000, 16'h0300, 16'h5A5A, 16'h0F0F,  1, 16'h0300, 1,  2, 16'h1234, 16'hBEEF, 0};
    table_v[3] = '{0, 1, 1, 0, 16'h0020, 16'h0999, 16'h0000, 16'hC0DE,  3, 16'h0020, 0,  4, 16'hC0DE, 16'hC0DE, 0};
    table_v[4] = '{0, 1, 0, 0, 16'h0050, 16'h0000, 16'h0000, 16'h7777, 20, 16'h0050, 0, 16, 16'hC0DE, 16'hC0DE, 1};

    repeat (2) @(negedge CLK);
    check("rst_req", 32'(mem_req), 0);
    check("rst_regs", 32'({mem_addr, ir}), 0);
    check("rst_mdr", 32'({mdr, mem_wdata}), 0);
    check("rst_flags", 32'({bus_err, mem_we, stall}), 0);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) run_access(table_v[i]);

    // Asynchronous reset in the middle of a fetch
    @(negedge CLK);
    IRWrite = 1'b1; pc = 16'h0040;
    @(negedge CLK);
    IRWrite = 1'b0;
    @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    check("midrst_req", 32'(mem_req), 0);
    check("midrst_ir", 32'(ir), 0);
    check("midrst_berr", 32'(bus_err), 0);
    check("midrst_addr", 32'(mem_addr), 0);
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    check("postrst_idle", 32'({mem_req, stall}), 0);

    // Ack while idle must do nothing
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    #1;
    check("idle_ack_stall", 32'(stall), 0);
    @(negedge CLK);
    mem_ack = 1'b0;
    check("idle_ack_regs", 32'({mem_req, ir}), 0);

    // Write colliding with a read: one write transaction, error flagged
    v = '{1, 0, 1, 1, 16'h0000, 16'h0400, 16'h1111, 16'h2222, 0, 16'h0400, 1, 1, 16'h0000, 16'h0000, 1};
    run_access(v);
    v = '{0, 1, 0, 0, 16'h0060, 16'h0000, 16'h0000, 16'h3333, 0, 16'h0060, 0, 1, 16'h3333, 16'h0000, 1};
    run_access(v);

    // Randomized accesses against a transaction-level model
    pulse_reset();
    m_ir = '0; m_mdr = '0; m_berr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      v.iod = 1'($urandom_range(0, 1));
      do begin
        v.irw = 1'($urandom_range(0, 1));
        v.mr  = 1'($urandom_range(0, 1));
        v.mw  = ($urandom_range(0, 3) == 0);
      end while (!(v.irw || v.mr || v.mw));
      v.pc = 16'($urandom); v.alu = 16'($urandom);
      v.wd = 16'($urandom); v.rd = 16'($urandom);
      v.delay = (n < 25) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, TIMEOUT + 3));
      acked = (v.delay <= TIMEOUT);
      v.e_addr  = v.iod ? v.alu : v.pc;
      v.e_we    = v.mw;
      v.e_stall = acked ? v.delay + 1 : TIMEOUT + 1;
      if (v.mw && (v.irw || v.mr)) m_berr = 1'b1;
      if (!acked) m_berr = 1'b1;
      else if (!v.mw) begin
        if (v.irw) m_ir  = v.rd;
        if (v.mr)  m_mdr = v.rd;
      end
      v.e_ir = m_ir; v.e_mdr = m_mdr; v.e_berr = m_berr;
      run_access(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access stage of the 16-bit multi-cycle processor, directly downstream of the control FSM. It turns the FSM's IoD/IRWrite/MemR/MemW strobes into single-port memory transactions with a req/ack handshake. It also owns the instruction register (IR) and memory data register (MDR). It feeds IR[6:0] back to the control FSM as its 7-bit control input, and it stalls the processor while memory is busy.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory/instruction data width
- TIMEOUT, 15, maximum BUSY cycles without ack before abort (1..255)

Clock and reset: one clock; reset is asynchronous and active-high (CLK, Reset).

- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- IoD  in  1  address select: 0 = pc, 1 = alu_out
- IRWrite  in  1  instruction fetch: read, result to IR
- MemR  in  1  data read: result to MDR
- MemW  in  1  data write of wdata
- pc  in  ADDR_W  program counter
- alu_out  in  ADDR_W  ALU result register (data address)
- wdata  in  DATA_W  store data
- mem_addr  out  ADDR_W  registered memory address
- mem_req  out  1  registered request, held until ack or abort
- mem_we  out  1  registered write enable, valid with mem_req
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  read data, valid in the ack cycle
- mem_ack  in  1  one-cycle completion from memory
- ir  out  DATA_W  instruction register
- mdr  out  DATA_W  memory data register
- input_control  out  7  equals ir[6:0] ({funct4, opcode}) to the control FSM
- stall  out  1  processor clock enable low; the FSM and PC hold while high
- bus_err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY.
- IDLE, no strobe: stall=0, mem_req=0.
- IDLE with any strobe (IRWrite | MemR | MemW):
  - stall=1, combinational, in the same cycle.
  - On the clock edge, latch mem_addr = IoD ? alu_out : pc, mem_we = MemW, mem_wdata = wdata, and a destination tag (IR, MDR or both). Set mem_req=1 and go to BUSY.
- Simultaneous strobes:
  - IRWrite & MemR: one read; data loads both IR and MDR.
  - MemW with any read strobe: only the write is performed, and bus_err is set.
- BUSY, mem_ack=0: stall=1; wait counter increments.
- BUSY, mem_ack=1:
  - stall=0 in that cycle.
  - On the edge: a read loads its destination from mem_rdata; mem_req drops; counter clears; go to IDLE.
- BUSY when the counter reaches TIMEOUT with no ack:
  - stall=0 in that cycle.
  - On the edge: mem_req drops, bus_err is set, IR and MDR keep their old values, go to IDLE.
- mem_ack in IDLE is ignored.
- bus_err is cleared only by Reset.
- input_control is always a direct copy of ir[6:0].

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - State returns to IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ir=0, mdr=0, bus_err=0, counter=0.
  - stall then follows the strobes combinationally.
- Minimum latency is 2 cycles: strobe cycle, then a BUSY cycle with ack. IR/MDR are updated at the end of the ack cycle.
- A read with k cycles of ack delay after the first BUSY cycle holds stall for k+1 cycles.
- mem_addr, mem_we and mem_wdata are stable from the entry edge until mem_req falls.
- Back-to-back accesses: the FSM's next-state strobe can be accepted in the cycle right after the ack. There is no idle bubble beyond IDLE's single strobe cycle.
- The counter is $clog2(TIMEOUT+1) bits wide, saturates at TIMEOUT, and never wraps.

## Structure
- Shared package (proc_pkg):
  - mem_state_t enum {IDLE, BUSY}
  - destination tag enum {DST_NONE, DST_IR, DST_MDR, DST_BOTH}
  - instruction field constants OPC_LSB=0, OPC_W=3, FUNCT_LSB=3, FUNCT_W=4
- Sub-module mem_wait_timer: clear/enable saturating counter with a `expired` output. It is the only natural split.
- The rest (FSM, IR/MDR, output registers) stays in mem_access_unit.

## Test plan
- Reset asserted mid-BUSY with pc=0x0040 -> same cycle: mem_req=0, ir=0, bus_err=0; after release, the state is IDLE.
- Fetch with IRWrite=1, IoD=0, pc=0x0010, mem_rdata=0x1234, ack 2 cycles after req -> mem_addr=0x0010, stall high for 3 cycles, then ir=0x1234 and input_control=7'h34.
- Load with MemR=1, IoD=1, alu_out=0x0200, immediate ack, rdata=0xBEEF -> mdr=0xBEEF after 2 cycles; ir unchanged.
- Store with MemW=1, IoD=1, alu_out=0x0300, wdata=0x5A5A -> mem_we=1, mem_wdata=0x5A5A, mem_addr=0x0300; ir and mdr unchanged.
- No ack for TIMEOUT=15 cycles -> mem_req drops on cycle 15, bus_err=1 and stays 1, ir keeps its old value, stall=0 in the expiring cycle.
- MemW and MemR asserted together -> a single write transaction and bus_err=1; IRWrite & MemR together -> one read, ir = mdr = rdata.
